apb_master_bridge: RTL
======================

# apb_master_bridge

APB initiator between the RV32I multi-cycle core's data-bus port and the APB peripheral bus. It accepts one-cycle load/store requests from the core and decodes the address to one of four slave selects. It runs the APB SETUP/ACCESS sequence, waits for the selected slave's PREADY, and returns read data plus a completion strobe. It is the counterpart to every APB slave register interface in the SoC: the GPIO, GPO, UART and timer slaves all hang off it.

## Interface
- TIMEOUT_CYC, 255: ACCESS cycles allowed without PREADY before abort. Only used with APB_TIMEOUT_EN; range 1..65535.
- PCLK  in  1  single system clock, rising edge.
- PRESET  in  1  synchronous, active-low reset, sampled on PCLK rising edge.
- transfer  in  1  core request strobe, one cycle. Sampled only in IDLE.
- write  in  1  1 = store, 0 = load. Sampled with transfer.
- addr  in  32  byte address. Sampled with transfer.
- wdata  in  32  store data. Sampled with transfer.
- rdata  out  32  load data, valid only while ready=1.
- ready  out  1  completion strobe, one cycle per accepted request.
- err  out  1  error qualifier, valid only while ready=1.
- PADDR  out  32  latched request address.
- PWRITE  out  1  latched write.
- PWDATA  out  32  latched wdata.
- PENABLE  out  1  APB enable.
- PSEL0..PSEL3  out  1 each  one-hot slave selects.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY0..PREADY3  in  1 each  slave ready.

## Operation
- Address map:
  - addr[31:16] must equal 0x1000, otherwise the address is unmapped.
  - Slave index = addr[15:12]. Index 0..3 selects PSELn; index 4..15 is unmapped.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - transfer=1 with a mapped address: latch addr/write/wdata into PADDR/PWRITE/PWDATA and the slave index, then go to SETUP.
  - transfer=1 with an unmapped address: go to ERR. No PSEL is asserted.
  - transfer=0: stay in IDLE.
- SETUP: PSEL[idx]=1, PENABLE=0. Always moves to ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1.
  - If PREADY[idx]=1: ready=1, err=0, rdata=PRDATA[idx] (combinational mux; forced to 0 on writes), then go to IDLE.
  - Otherwise stay in ACCESS.
- ERR: ready=1, err=1, rdata=0. Go to IDLE.
- PREADY and PRDATA of non-selected slaves are ignored.
- transfer asserted outside IDLE is dropped. The core must not issue a new request until it has seen ready.
- PADDR, PWRITE and PWDATA hold their latched values from SETUP until the next accepted request.
- The slave index is never outside 0..3 in SETUP or ACCESS.

## Timing
- Reset (PRESET=0 at an edge) forces the following on the next edge, including mid-transfer:
  - state=IDLE;
  - PADDR=0, PWDATA=0, PWRITE=0, PENABLE=0, PSEL0..3=0;
  - ready=0, err=0, rdata=0.
- An aborted APB transfer is not replayed.
- Mapped request, with transfer at cycle T:
  - cycle T+1: SETUP.
  - cycle T+2: ACCESS.
  - ready appears in the first ACCESS cycle that sees PREADY[idx]=1.
  - Zero-wait slave: ready at T+2. Registered-PREADY slave (PREADY one cycle after PSEL&PENABLE): ready at T+3.
- Unmapped request: ready=1 and err=1 at T+1.
- ready is high exactly one cycle. The next request can be accepted in the cycle after ready, since the FSM is back in IDLE.
- PENABLE and PSEL drop in the cycle after ready. No back-to-back SETUP without passing through IDLE.
- PSEL is never asserted for more than one slave. All PSEL are 0 in IDLE and ERR.

## Configuration
- APB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter equals TIMEOUT_CYC and PREADY[idx]=0: ready=1, err=1, rdata=0, go to IDLE. PSEL and PENABLE drop on the next edge.
  - PREADY arriving in the same cycle as the timeout takes priority: normal completion, err=0.
- APB_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - err is raised only for unmapped addresses.
  - TIMEOUT_CYC is unused.

## Test plan
- Reset: hold PRESET=0 for 2 edges while transfer=1 -> all outputs 0 and no PSEL asserted; release -> still idle.
- Write to GPIO slave: transfer, write=1, addr=0x1000_1004, wdata=0x0000_00A5 -> PSEL1=1 at T+1 with PENABLE=0; PENABLE=1 at T+2; slave PREADY at T+3 -> ready=1, err=0 at T+3; PSEL1=0 at T+4; PADDR=0x1000_1004 and PWDATA=0xA5 throughout.
- Read from slave 2, zero-wait: addr=0x1000_2008, PRDATA2=0x1234_5678 with PREADY2 tied high -> ready=1 and rdata=0x1234_5678 at T+2; PSEL0/1/3 stay 0.
- Unmapped addresses: addr=0x1000_5000 -> ready=1, err=1, rdata=0 at T+1 and no PSEL; repeat with addr=0x2000_0000 -> same.
- Wait states plus dropped request: slave 3 holds PREADY low for 5 ACCESS cycles and a second transfer pulse is sent mid-wait -> one ready only, then the FSM returns to IDLE with no second SETUP.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC=4): slave 0 never ready -> ready=1, err=1 at T+6 and PSEL0=0 at T+7. With the same stimulus and the macro undefined, ready stays 0 for 1000 cycles.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator bridging the core data-bus port to four APB slaves (SETUP/ACCESS, error on unmapped).
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic        PENABLE,
   output logic        PSEL0,
   output logic        PSEL1,
   output logic        PSEL2,
   output logic        PSEL3,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3,
   output logic [1:0]  fsm_state
);

   // Handshake: the core pulses transfer for one cycle while the bridge is idle; the bridge
   // answers with exactly one ready pulse (err/rdata qualified by ready). Requests seen while
   // busy are dropped; the slave side completes an ACCESS cycle when its PREADY is high.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYC out of range 1..65535");
   end

   state_t      state, state_nx;
   logic [1:0]  idx;
   logic        mapped;
   logic        accept;
   logic        sel_pready;
   logic [31:0] sel_prdata;
   logic [3:0]  psel;
   logic        timeout;

   assign mapped    = (addr[31:16] == 16'h1000) && (addr[15:14] == 2'b00);
   assign accept    = (state == S_IDLE) && transfer && mapped;
   assign fsm_state = state;

   always_comb begin
      sel_pready = PREADY0;
      sel_prdata = PRDATA0;
      case (idx)
         2'd0: begin sel_pready = PREADY0; sel_prdata = PRDATA0; end
         2'd1: begin sel_pready = PREADY1; sel_prdata = PRDATA1; end
         2'd2: begin sel_pready = PREADY2; sel_prdata = PRDATA2; end
         default: begin sel_pready = PREADY3; sel_prdata = PRDATA3; end
      endcase
   end

`ifdef APB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   // Every entry into ACCESS comes from SETUP, so clearing there restarts the count per transfer.
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         wait_cnt <= 16'd0;
      end else if (state == S_SETUP) begin
         wait_cnt <= 16'd0;
      end else if (state == S_ACCESS && !sel_pready) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   assign timeout = (state == S_ACCESS) && !sel_pready && (wait_cnt == 16'(TIMEOUT_CYC));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         idx    <= 2'd0;
         PADDR  <= 32'd0;
         PWRITE <= 1'b0;
         PWDATA <= 32'd0;
      end else if (accept) begin
         idx    <= addr[13:12];
         PADDR  <= addr;
         PWRITE <= write;
         PWDATA <= wdata;
      end
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      err      = 1'b0;
      rdata    = 32'd0;
      PENABLE  = 1'b0;
      psel     = 4'b0000;
      case (state)
         S_IDLE: begin
            if (transfer) begin
               state_nx = mapped ? S_SETUP : S_ERR;
            end
         end
         S_SETUP: begin
            psel[idx] = 1'b1;
            state_nx  = S_ACCESS;
         end
         S_ACCESS: begin
            psel[idx] = 1'b1;
            PENABLE   = 1'b1;
            // PREADY wins over a timeout landing in the same cycle.
            if (sel_pready) begin
               ready    = 1'b1;
               rdata    = PWRITE ? 32'd0 : sel_prdata;
               state_nx = S_IDLE;
            end else if (timeout) begin
               ready    = 1'b1;
               err      = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: begin
            ready    = 1'b1;
            err      = 1'b1;
            state_nx = S_IDLE;
         end
      endcase
   end

   assign PSEL0 = psel[0];
   assign PSEL1 = psel[1];
   assign PSEL2 = psel[2];
   assign PSEL3 = psel[3];

endmodule
